// File: rtl/qos_wrr.sv
// qos_wrr: per-class FIFOs drained by a weighted round-robin arbiter into a
// single registered output stage, supervised by an INIT/IDLE/ACTIVE/ERROR FSM.
module qos_wrr #(
   parameter int DATA_W   = 8,
   parameter int NUM_CH   = 4,
   parameter int DEPTH    = 8,
   parameter int WEIGHT_W = 4,
   parameter int AF_LVL   = DEPTH - 2
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         init,
   input  logic [NUM_CH*WEIGHT_W-1:0]   WEIGHTS,
   input  logic                         WRITE,
   input  logic [$clog2(NUM_CH)-1:0]    WR_CH,
   input  logic [DATA_W-1:0]            DATA_IN,
   input  logic                         READY,
   output logic                         VALID,
   output logic [DATA_W-1:0]            DATA_OUT,
   output logic [$clog2(NUM_CH)-1:0]    SRC_CH,
   output logic [NUM_CH-1:0]            EMPTY,
   output logic [NUM_CH-1:0]            FULL,
   output logic [NUM_CH-1:0]            ALMOST_FULL,
   output logic                         PAUSE,
   output logic                         ERR_OVERFLOW,
   output logic [1:0]                   STATE
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   logic [DATA_W-1:0]          mem_q     [NUM_CH][DEPTH];
   logic [PTR_W-1:0]           wrPtr_q   [NUM_CH];
   logic [PTR_W-1:0]           rdPtr_q   [NUM_CH];
   logic [CNT_W-1:0]           count_q   [NUM_CH];
   logic [CNT_W-1:0]           count_d   [NUM_CH];

   logic [NUM_CH*WEIGHT_W-1:0] weights_q, weights_d;
   logic [CH_W-1:0]            grant_q, grant_d;
   logic [WEIGHT_W-1:0]        burst_q, burst_d;
   state_t                     state_q, state_d;
   logic                       valid_q, valid_d;
   logic [DATA_W-1:0]          dataOut_q, dataOut_d;
   logic [CH_W-1:0]            srcCh_q, srcCh_d;
   logic                       errOvf_q, errOvf_d;

   logic [NUM_CH-1:0]          classEmpty, classFull, classAf;
   logic [NUM_CH-1:0]          pushV, popV;
   logic [CH_W-1:0]            selCh;
   logic [WEIGHT_W-1:0]        selW, burstLimit, burstBase;
   logic [WEIGHT_W:0]          burstNext;
   logic                       lastPop, popEn, overflow, wrInRange;

   // First non-empty class after 'from' in cyclic order, ending with 'from' itself.
   function automatic logic [CH_W-1:0] nextNonEmpty(input logic [CH_W-1:0] from,
                                                    input logic [NUM_CH-1:0] emp);
      logic [CH_W-1:0] pick;
      logic [CH_W-1:0] cand;
      logic            found;
      int              idx;
      pick  = from;
      found = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx  = (int'(from) + k) % NUM_CH;
         cand = CH_W'(idx);
         if (!found && !emp[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // Status flags decoded straight from each class occupancy counter.
   always_comb begin
      classEmpty = '0;
      classFull  = '0;
      classAf    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         classEmpty[c] = (count_q[c] == '0);
         classFull[c]  = (count_q[c] == CNT_W'(DEPTH));
         classAf[c]    = (count_q[c] >= CNT_W'(AF_LVL));
      end
   end

   // Pick the class to serve: the grant pointer, or the next non-empty class when it has run dry.
   always_comb begin
      selCh      = classEmpty[grant_q] ? nextNonEmpty(grant_q, classEmpty) : grant_q;
      selW       = weights_q[selCh*WEIGHT_W +: WEIGHT_W];
      burstLimit = (selW == '0) ? WEIGHT_W'(1) : selW;
      burstBase  = (selCh == grant_q) ? burst_q : '0;
      burstNext  = {1'b0, burstBase} + (WEIGHT_W+1)'(1);
      lastPop    = (burstNext >= {1'b0, burstLimit});
      popEn      = (state_q == ST_ACTIVE) && !classEmpty[selCh] && (!valid_q || READY);
   end

   // Per-class push/pop strobes; a write to a full class only lands if that class is popped too.
   always_comb begin
      popV      = '0;
      pushV     = '0;
      overflow  = 1'b0;
      wrInRange = (int'(WR_CH) < NUM_CH);
      if (popEn) begin
         popV[selCh] = 1'b1;
      end
      if (WRITE && wrInRange) begin
         if (!classFull[WR_CH] || popV[WR_CH]) begin
            pushV[WR_CH] = 1'b1;
         end else begin
            overflow = 1'b1;
         end
      end
   end

   // Next occupancy per class; simultaneous push and pop leave it unchanged.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         count_d[c] = count_q[c];
         if (pushV[c] && !popV[c]) begin
            count_d[c] = count_q[c] + CNT_W'(1);
         end else if (popV[c] && !pushV[c]) begin
            count_d[c] = count_q[c] - CNT_W'(1);
         end
      end
   end

   // FIFO pointers and counters; reset discards whatever is stored.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wrPtr_q[c] <= '0;
            rdPtr_q[c] <= '0;
            count_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (pushV[c]) begin
               wrPtr_q[c] <= wrPtr_q[c] + PTR_W'(1);
            end
            if (popV[c]) begin
               rdPtr_q[c] <= rdPtr_q[c] + PTR_W'(1);
            end
            count_q[c] <= count_d[c];
         end
      end
   end

   // Storage array; contents need no reset because the counters gate every read.
   always_ff @(posedge CLK) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (RESET && pushV[c]) begin
            mem_q[c][wrPtr_q[c]] <= DATA_IN;
         end
      end
   end

   // Next-state for FSM, arbiter, weights and the output register.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      burst_d   = burst_q;
      weights_d = weights_q;
      valid_d   = valid_q;
      dataOut_d = dataOut_q;
      srcCh_d   = srcCh_q;
      errOvf_d  = errOvf_q;

      if (init) begin
         weights_d = WEIGHTS;
      end

      if (popEn) begin
         valid_d   = 1'b1;
         dataOut_d = mem_q[selCh][rdPtr_q[selCh]];
         srcCh_d   = selCh;
         if (lastPop) begin
            grant_d = nextNonEmpty(selCh, classEmpty);
            burst_d = '0;
         end else begin
            grant_d = selCh;
            burst_d = burstNext[WEIGHT_W-1:0];
         end
      end else if (valid_q && READY) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_INIT: begin
            if (init) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (!(&classEmpty) || (|pushV)) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if ((&classEmpty) && !popEn && !(|pushV)) state_d = ST_IDLE;
         end
         ST_ERROR: begin
            if (init) begin
               state_d  = ST_IDLE;
               errOvf_d = 1'b0;
            end
         end
         default: state_d = ST_INIT;
      endcase

      if (overflow) begin
         errOvf_d = 1'b1;
         state_d  = ST_ERROR;
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q   <= ST_INIT;
         grant_q   <= '0;
         burst_q   <= '0;
         weights_q <= {NUM_CH{WEIGHT_W'(1)}};
         valid_q   <= 1'b0;
         dataOut_q <= '0;
         srcCh_q   <= '0;
         errOvf_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         burst_q   <= burst_d;
         weights_q <= weights_d;
         valid_q   <= valid_d;
         dataOut_q <= dataOut_d;
         srcCh_q   <= srcCh_d;
         errOvf_q  <= errOvf_d;
      end
   end

   assign VALID        = valid_q;
   assign DATA_OUT     = dataOut_q;
   assign SRC_CH       = srcCh_q;
   assign EMPTY        = classEmpty;
   assign FULL         = classFull;
   assign ALMOST_FULL  = classAf;
   assign PAUSE        = |classAf;
   assign ERR_OVERFLOW = errOvf_q;
   assign STATE        = state_q;

endmodule

// File: tb/tb_qos_wrr.sv
// tb_qos_wrr: directed table-driven and hand-sequenced checks for qos_wrr.
module tb_qos_wrr;

   localparam int DATA_W   = 8;
   localparam int NUM_CH   = 4;
   localparam int DEPTH    = 8;
   localparam int WEIGHT_W = 4;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        initP = 1'b0;
   logic [15:0] weights = 16'h1111;
   logic        write = 1'b0;
   logic [1:0]  wrCh = 2'd0;
   logic [7:0]  dataIn = 8'h00;
   logic        ready = 1'b0;

   logic        valid;
   logic [7:0]  dataOut;
   logic [1:0]  srcCh;
   logic [3:0]  empty;
   logic [3:0]  full;
   logic [3:0]  almostFull;
   logic        pause;
   logic        errOvf;
   logic [1:0]  state;

   int testsRun = 0;
   int testsFailed = 0;

   logic [7:0] expQ[$];
   logic [1:0] srcQ[$];

   typedef struct {
      logic        rstN;
      logic        initP;
      logic [15:0] w;
      logic        wr;
      logic [1:0]  ch;
      logic [7:0]  din;
      logic        rdy;
      logic        expValid;
      logic [7:0]  expData;
      logic [1:0]  expSrc;
      logic [3:0]  expEmpty;
      logic [1:0]  expState;
      logic        expErr;
   } vec_t;

   vec_t vecs[10];

   qos_wrr #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH),
      .WEIGHT_W(WEIGHT_W), .AF_LVL(DEPTH-2)
   ) dut (
      .CLK(clk), .RESET(rstN), .init(initP), .WEIGHTS(weights),
      .WRITE(write), .WR_CH(wrCh), .DATA_IN(dataIn), .READY(ready),
      .VALID(valid), .DATA_OUT(dataOut), .SRC_CH(srcCh), .EMPTY(empty),
      .FULL(full), .ALMOST_FULL(almostFull), .PAUSE(pause),
      .ERR_OVERFLOW(errOvf), .STATE(state)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Safety net so a hung handshake cannot stall the run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d", testsRun);
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rstN    = v.rstN;
      initP   = v.initP;
      weights = v.w;
      write   = v.wr;
      wrCh    = v.ch;
      dataIn  = v.din;
      ready   = v.rdy;
   endtask

   task automatic doReset();
      rstN  = 1'b0;
      write = 1'b0;
      initP = 1'b0;
      ready = 1'b0;
      tick();
      rstN = 1'b1;
   endtask

   task automatic doInit(input logic [15:0] w);
      initP   = 1'b1;
      weights = w;
      tick();
      initP = 1'b0;
   endtask

   task automatic writeWord(input logic [1:0] ch, input logic [7:0] d);
      write  = 1'b1;
      wrCh   = ch;
      dataIn = d;
      tick();
      write = 1'b0;
   endtask

   // Holds READY high and compares every presented word against expQ/srcQ in order.
   task automatic drainCheck(input string name, input int budget);
      int got = 0;
      int n = expQ.size();
      int cycles = 0;
      ready = 1'b1;
      while (got < n && cycles < budget) begin
         if (valid) begin
            checkOutput($sformatf("%s data[%0d]", name, got), dataOut, expQ[got]);
            checkOutput($sformatf("%s src[%0d]", name, got), srcCh, srcQ[got]);
            got++;
         end
         if (got < n) begin
            tick();
            cycles++;
         end
      end
      if (got < n) begin
         checkOutput($sformatf("%s words delivered before timeout", name), got, n);
      end
      tick();
      checkOutput($sformatf("%s valid after drain", name), valid, 1'b0);
      checkOutput($sformatf("%s empty after drain", name), empty, 4'hF);
      expQ.delete();
      srcQ.delete();
   endtask

   initial begin
      // Basic path: reset, init, single word, back-to-back words, class skipping.
      vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 4'hF, 2'd0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 16'h1111, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 4'hF, 2'd1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 16'h1111, 1'b1, 2'd2, 8'hA1, 1'b1, 1'b0, 8'h00, 2'd0, 4'hB, 2'd2, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 16'h1111, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hA1, 2'd2, 4'hF, 2'd2, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 16'h1111, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'hA1, 2'd2, 4'hF, 2'd1, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 16'h1111, 1'b1, 2'd0, 8'h10, 1'b1, 1'b0, 8'hA1, 2'd2, 4'hE, 2'd2, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 16'h1111, 1'b1, 2'd0, 8'h11, 1'b1, 1'b1, 8'h10, 2'd0, 4'hE, 2'd2, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 16'h1111, 1'b1, 2'd3, 8'h33, 1'b1, 1'b1, 8'h11, 2'd0, 4'h7, 2'd2, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 16'h1111, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h33, 2'd3, 4'hF, 2'd2, 1'b0};
      vecs[9] = '{1'b1, 1'b0, 16'h1111, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h33, 2'd3, 4'hF, 2'd1, 1'b0};

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d valid", i), valid, vecs[i].expValid);
         checkOutput($sformatf("vec%0d data", i), dataOut, vecs[i].expData);
         checkOutput($sformatf("vec%0d src", i), srcCh, vecs[i].expSrc);
         checkOutput($sformatf("vec%0d empty", i), empty, vecs[i].expEmpty);
         checkOutput($sformatf("vec%0d state", i), state, vecs[i].expState);
         checkOutput($sformatf("vec%0d err", i), errOvf, vecs[i].expErr);
         if (i == 0) begin
            checkOutput("reset full", full, 4'h0);
            checkOutput("reset almostFull", almostFull, 4'h0);
            checkOutput("reset pause", pause, 1'b0);
         end
      end
      write = 1'b0;

      // Weighted service plus backpressure: class 0 weight 3, others 1, four words each.
      doReset();
      doInit(16'h1113);
      ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) begin
            writeWord(2'(c), 8'((c << 4) | k));
         end
      end
      checkOutput("wrr preload valid", valid, 1'b1);
      checkOutput("wrr preload data", dataOut, 8'h00);
      checkOutput("wrr preload empty", empty, 4'h0);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput($sformatf("backpressure hold data c%0d", k), dataOut, 8'h00);
         checkOutput($sformatf("backpressure hold valid c%0d", k), valid, 1'b1);
         checkOutput($sformatf("backpressure hold src c%0d", k), srcCh, 2'd0);
      end
      expQ = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h20, 8'h30, 8'h03, 8'h11,
               8'h21, 8'h31, 8'h12, 8'h22, 8'h32, 8'h13, 8'h23, 8'h33};
      srcQ = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1,
               2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
      drainCheck("wrr", 64);

      // Overflow: prime the output from class 0, then overfill class 1 with no pops.
      doReset();
      doInit(16'h1111);
      ready = 1'b0;
      writeWord(2'd0, 8'hEE);
      for (int i = 0; i < DEPTH + 1; i++) begin
         writeWord(2'd1, 8'(8'h40 + i));
         if (i < DEPTH) begin
            checkOutput($sformatf("ovf full1 w%0d", i), full[1], (i == DEPTH - 1));
            checkOutput($sformatf("ovf af1 w%0d", i), almostFull[1], (i + 1 >= DEPTH - 2));
            checkOutput($sformatf("ovf pause w%0d", i), pause, (i + 1 >= DEPTH - 2));
            checkOutput($sformatf("ovf err w%0d", i), errOvf, 1'b0);
            checkOutput($sformatf("ovf state w%0d", i), state, 2'd2);
         end else begin
            checkOutput("ovf full1 dropped", full[1], 1'b1);
            checkOutput("ovf err set", errOvf, 1'b1);
            checkOutput("ovf state error", state, 2'd3);
         end
      end
      checkOutput("ovf held data", dataOut, 8'hEE);
      doInit(16'h1111);
      checkOutput("ovf init state", state, 2'd1);
      checkOutput("ovf init clears err", errOvf, 1'b0);
      checkOutput("ovf init keeps full", full[1], 1'b1);
      expQ.push_back(8'hEE);
      srcQ.push_back(2'd0);
      for (int i = 0; i < DEPTH; i++) begin
         expQ.push_back(8'(8'h40 + i));
         srcQ.push_back(2'd1);
      end
      drainCheck("ovf", 64);

      // Full class popped and written in the same cycle, continuing through pointer wrap.
      doReset();
      doInit(16'h1111);
      ready = 1'b0;
      writeWord(2'd0, 8'hEE);
      for (int i = 0; i < DEPTH; i++) begin
         writeWord(2'd2, 8'(8'h50 + i));
      end
      checkOutput("bnd full2 before", full[2], 1'b1);
      checkOutput("bnd err before", errOvf, 1'b0);
      ready = 1'b1;
      for (int i = DEPTH; i < 2 * DEPTH; i++) begin
         writeWord(2'd2, 8'(8'h50 + i));
         checkOutput($sformatf("bnd full2 w%0d", i), full[2], 1'b1);
         checkOutput($sformatf("bnd err w%0d", i), errOvf, 1'b0);
         checkOutput($sformatf("bnd state w%0d", i), state, 2'd2);
         checkOutput($sformatf("bnd data w%0d", i), dataOut, 8'(8'h50 + i - DEPTH));
      end
      for (int i = DEPTH - 1; i < 2 * DEPTH; i++) begin
         expQ.push_back(8'(8'h50 + i));
         srcQ.push_back(2'd2);
      end
      drainCheck("wrap", 64);

      // Reset while a word is presented and classes still hold data.
      doReset();
      doInit(16'h1111);
      ready = 1'b0;
      writeWord(2'd3, 8'h77);
      writeWord(2'd3, 8'h78);
      writeWord(2'd1, 8'h79);
      checkOutput("midrst valid before", valid, 1'b1);
      checkOutput("midrst empty before", empty, 4'h5);
      rstN   = 1'b0;
      initP  = 1'b1;
      write  = 1'b1;
      wrCh   = 2'd1;
      dataIn = 8'h99;
      ready  = 1'b1;
      tick();
      checkOutput("midrst valid", valid, 1'b0);
      checkOutput("midrst data", dataOut, 8'h00);
      checkOutput("midrst empty", empty, 4'hF);
      checkOutput("midrst state", state, 2'd0);
      checkOutput("midrst err", errOvf, 1'b0);
      rstN  = 1'b1;
      initP = 1'b0;
      write = 1'b0;
      tick();
      checkOutput("midrst stays init", state, 2'd0);
      doInit(16'h1111);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput($sformatf("midrst discarded valid c%0d", k), valid, 1'b0);
         checkOutput($sformatf("midrst discarded empty c%0d", k), empty, 4'hF);
      end
      checkOutput("midrst idle state", state, 2'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/qos_wrr.md
QOS_WRR -- requirements
Module: qos_wrr

Interface
REQ-001 The module SHALL expose the following parameters:
  - DATA_W, default 8: word width.
  - NUM_CH, default 4: class FIFO count (2..8).
  - DEPTH, default 8: words per class FIFO (power of 2, >=4).
  - WEIGHT_W, default 4: per-class weight width.
  - AF_LVL, default DEPTH-2: almost-full occupancy threshold.
REQ-002 The module SHALL have the following ports:
  - CLK  in  1: single clock; all logic on rising edge.
  - RESET  in  1: synchronous, active-low reset.
  - init  in  1: one-cycle pulse; latches WEIGHTS and leaves INIT/ERROR state.
  - WEIGHTS  in  NUM_CH*WEIGHT_W: per-class weights, class c at bits [c*WEIGHT_W +: WEIGHT_W].
  - WRITE  in  1: push DATA_IN into class WR_CH.
  - WR_CH  in  clog2(NUM_CH): target class of the push.
  - DATA_IN  in  DATA_W: push data.
  - READY  in  1: downstream accepts DATA_OUT this cycle.
  - VALID  out  1: DATA_OUT holds a valid word.
  - DATA_OUT  out  DATA_W: registered output word.
  - SRC_CH  out  clog2(NUM_CH): class of the DATA_OUT word.
  - EMPTY  out  NUM_CH: per-class empty.
  - FULL  out  NUM_CH: per-class full.
  - ALMOST_FULL  out  NUM_CH: per-class occupancy >= AF_LVL.
  - PAUSE  out  1: upstream stall, OR of ALMOST_FULL.
  - ERR_OVERFLOW  out  1: sticky flag; write to a full class was dropped.
  - STATE  out  2: FSM state code.

Function
REQ-003 Each class SHALL own a DEPTH-entry FIFO with a clog2(DEPTH)+1-bit occupancy counter; EMPTY, FULL and ALMOST_FULL SHALL be decoded combinationally from that counter.
REQ-004 A WRITE to a class that is not full SHALL store DATA_IN at the class write pointer; pointers SHALL wrap modulo DEPTH.
REQ-005 A WRITE to a full class SHALL be dropped and SHALL set ERR_OVERFLOW, unless that class is popped in the same cycle; in that case the write SHALL be accepted and occupancy SHALL stay DEPTH.
REQ-006 A word written at edge k SHALL NOT be popped before edge k+1; there is no FIFO bypass.
REQ-007 The output stage SHALL be one register. A pop SHALL occur when state is ACTIVE, the granted class is non-empty, and (VALID==0 or READY==1).
REQ-008 A pop SHALL load DATA_OUT and SRC_CH and set VALID at the same edge. When VALID==1, READY==1 and no pop occurs, VALID SHALL clear. When VALID==1 and READY==0, DATA_OUT and SRC_CH SHALL be held.
REQ-009 Minimum latency SHALL be: write at edge k gives VALID=1 after edge k+1; sustained throughput SHALL be one word per cycle.
REQ-010 Arbitration SHALL be weighted round robin using a grant pointer g and a burst counter b.
REQ-011 Class g SHALL be served for up to max(W[g],1) consecutive pops. After the last pop, or when class g is empty, g SHALL advance to the next non-empty class in cyclic order (g+1 .. g-1, then g) and b SHALL reset to 0. Selecting the next class SHALL cost no idle cycle.
REQ-012 The FSM SHALL have four states: INIT=0, IDLE=1, ACTIVE=2, ERROR=3.
REQ-013 FSM transitions SHALL be:
  - INIT goes to IDLE on init.
  - IDLE goes to ACTIVE when any EMPTY bit is 0.
  - ACTIVE goes to IDLE when all classes are empty and no pop occurs this cycle.
  - Any state goes to ERROR when ERR_OVERFLOW sets.
  - ERROR goes to IDLE on init, which also clears ERR_OVERFLOW.
REQ-014 In ERROR no pops SHALL occur; a held DATA_OUT word SHALL still be delivered; writes SHALL continue to be accepted under REQ-004/005.
REQ-015 init in IDLE or ACTIVE SHALL re-latch WEIGHTS only; g and b SHALL be unchanged.

Reset
REQ-016 When RESET==0 at an edge, the module SHALL clear all pointers and counters, set g=0 and b=0, and apply these output values: VALID=0, DATA_OUT=0, SRC_CH=0, ERR_OVERFLOW=0, state=INIT, weights=1.
REQ-017 After reset, EMPTY SHALL be all 1, FULL all 0, ALMOST_FULL all 0 and PAUSE=0.
REQ-018 Reset SHALL override WRITE, READY and init in the same cycle. A reset mid-burst SHALL discard all stored data.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
  - Basic: reset, init with W={1,1,1,1}; write 0xA1 to class 2 -> after the next edge VALID=1, DATA_OUT=0xA1, SRC_CH=2.
  - Weighted: W={3,1,1,1}; preload 4 words in each class; hold READY=1 -> SRC_CH sequence 0,0,0,1,2,3,0,1,2,3...
  - Backpressure: READY=0 for 5 cycles with data queued -> DATA_OUT stable, no pops; READY=1 -> one word per cycle in order.
  - Full/overflow: write DEPTH+1 words to class 1 with no pops -> FULL[1]=1, ERR_OVERFLOW=1, STATE=3; init -> STATE=1, flag cleared, DEPTH words intact.
  - Boundary: class full while popped, with simultaneous write -> write accepted, occupancy stays DEPTH, no error; pointer wrap after 2*DEPTH words keeps data in order.
  - Reset mid-operation: RESET=0 while VALID=1 and classes hold data -> next cycle VALID=0, EMPTY all 1, STATE=0.
